// File: rtl/if_id_queue.sv
// Dual-wide fetch-to-decode instruction buffer: up to two pushes and two
// pops per cycle over a circular store, cleared in one cycle on flush.
module if_id_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid_0,
    input  logic          in_valid_1,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst_0,
    input  logic [31:0]   in_inst_1,
    input  logic [1:0]    in_exc,
    output logic          in_ready,
    output logic          out_valid_0,
    output logic          out_valid_1,
    output logic [31:0]   out_pc_0,
    output logic [31:0]   out_pc_1,
    output logic [31:0]   out_inst_0,
    output logic [31:0]   out_inst_1,
    output logic [1:0]    out_exc_0,
    input  logic [1:0]    out_pop,
    output logic [AW:0]   count
);

    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [1:0]    exc_q  [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [AW-1:0] rd1;
    logic [AW-1:0] wr1;
    logic [1:0]    avail;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;

    assign rd1 = rd_ptr_q + AW'(1);
    assign wr1 = wr_ptr_q + AW'(1);

    // Readiness looks only at the registered count, never at this cycle's pop.
    assign in_ready    = count_q <= (AW+1)'(DEPTH - 2);
    assign out_valid_0 = count_q != '0;
    assign out_valid_1 = (count_q >= (AW+1)'(2)) && (exc_q[rd_ptr_q] == 2'b00);

    assign out_pc_0   = out_valid_0 ? pc_q[rd_ptr_q]   : '0;
    assign out_inst_0 = out_valid_0 ? inst_q[rd_ptr_q] : '0;
    assign out_exc_0  = out_valid_0 ? exc_q[rd_ptr_q]  : '0;
    assign out_pc_1   = out_valid_1 ? pc_q[rd1]        : '0;
    assign out_inst_1 = out_valid_1 ? inst_q[rd1]      : '0;
    assign count      = count_q;

    always_comb begin
        avail  = {1'b0, out_valid_0} + {1'b0, out_valid_1};
        pop_n  = (out_pop > avail) ? avail : out_pop;
        push_n = 2'd0;
        if (in_ready && in_valid_0) begin
            // A faulting fetch carries only its own slot.
            push_n = ((in_exc != 2'b00) || !in_valid_1) ? 2'd1 : 2'd2;
        end
        rd_ptr_d = rd_ptr_q + AW'(pop_n);
        wr_ptr_d = wr_ptr_q + AW'(push_n);
        count_d  = count_q + {{(AW-1){1'b0}}, push_n}
                           - {{(AW-1){1'b0}}, pop_n};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!reset && !flush && (push_n != 2'd0)) begin
            pc_q[wr_ptr_q]   <= in_pc;
            inst_q[wr_ptr_q] <= in_inst_0;
            exc_q[wr_ptr_q]  <= in_exc;
            if (push_n == 2'd2) begin
                pc_q[wr1]   <= in_pc + 32'd4;
                inst_q[wr1] <= in_inst_1;
                exc_q[wr1]  <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid_0;
    logic          in_valid_1;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst_0;
    logic [31:0]   in_inst_1;
    logic [1:0]    in_exc;
    logic          in_ready;
    logic          out_valid_0;
    logic          out_valid_1;
    logic [31:0]   out_pc_0;
    logic [31:0]   out_pc_1;
    logic [31:0]   out_inst_0;
    logic [31:0]   out_inst_1;
    logic [1:0]    out_exc_0;
    logic [1:0]    out_pop;
    logic [AW:0]   count;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  exc;
    } ent_t;

    ent_t mq[$];

    if_id_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
        .in_pc(in_pc), .in_inst_0(in_inst_0), .in_inst_1(in_inst_1),
        .in_exc(in_exc), .in_ready(in_ready),
        .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
        .out_pc_0(out_pc_0), .out_pc_1(out_pc_1),
        .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
        .out_exc_0(out_exc_0), .out_pop(out_pop), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid_0 = 0; in_valid_1 = 0; in_pc = '0;
        in_inst_0 = '0; in_inst_1 = '0; in_exc = '0; out_pop = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        mq.delete();
    endtask

    task automatic push(input logic [31:0] pc, input int n);
        in_pc = pc; in_inst_0 = pc ^ 32'h5a5a0000;
        in_inst_1 = pc ^ 32'h0000a5a5;
        in_valid_0 = (n >= 1); in_valid_1 = (n >= 2);
    endtask

    // Reference: entries leave in FIFO order, at most two per cycle, and a
    // faulting head leaves alone; accept only when two slots are free.
    function automatic void model_step();
        int sz, avail, pop;
        ent_t e;
        sz = mq.size();
        if (flush) begin
            mq.delete();
            return;
        end
        avail = 0;
        if (sz >= 1) avail++;
        if (sz >= 2 && mq[0].exc == 2'b00) avail++;
        pop = (int'(out_pop) > avail) ? avail : int'(out_pop);
        for (int i = 0; i < pop; i++) void'(mq.pop_front());
        if ((DEPTH - sz >= 2) && in_valid_0) begin
            e.pc = in_pc; e.inst = in_inst_0; e.exc = in_exc;
            mq.push_back(e);
            if (in_exc == 2'b00 && in_valid_1) begin
                e.pc = in_pc + 32'd4; e.inst = in_inst_1; e.exc = 2'b00;
                mq.push_back(e);
            end
        end
    endfunction

    task automatic test_reset();
        do_reset();
        nchecks++;
        if (count !== 4'd0) begin
            nerr++; $display("FAIL reset_count got=%0d exp=0", count);
        end
        nchecks++;
        if ({in_ready, out_valid_0, out_valid_1} !== 3'b100) begin
            nerr++;
            $display("FAIL reset_flags got=%b exp=100",
                     {in_ready, out_valid_0, out_valid_1});
        end
        nchecks++;
        if ({out_pc_0, out_inst_0, out_exc_0} !== '0) begin
            nerr++; $display("FAIL reset_data got=%h exp=0", out_pc_0);
        end
    endtask

    task automatic test_first_push();
        do_reset();
        in_pc = 32'hbfc00000; in_inst_0 = 32'h24020001;
        in_inst_1 = 32'h24030002; in_valid_0 = 1; in_valid_1 = 1;
        #1;
        nchecks++;
        if (out_valid_0 !== 1'b0) begin
            nerr++; $display("FAIL no_bypass got=%b exp=0", out_valid_0);
        end
        tick();
        idle_inputs();
        nchecks++;
        if ({out_valid_0, out_valid_1} !== 2'b11) begin
            nerr++;
            $display("FAIL first_valid got=%b exp=11",
                     {out_valid_0, out_valid_1});
        end
        nchecks++;
        if (out_pc_1 !== 32'hbfc00004 || out_inst_1 !== 32'h24030002) begin
            nerr++;
            $display("FAIL first_slot1 got=%h/%h exp=bfc00004/24030002",
                     out_pc_1, out_inst_1);
        end
        nchecks++;
        if (out_pc_0 !== 32'hbfc00000 || count !== 4'd2) begin
            nerr++;
            $display("FAIL first_head got=%h cnt=%0d exp=bfc00000 cnt=2",
                     out_pc_0, count);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(32'h1000 + 32'(8 * i), 2);
            tick();
        end
        nchecks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL full got cnt=%0d rdy=%b exp cnt=8 rdy=0",
                     count, in_ready);
        end
        push(32'h2000, 2);
        tick();
        nchecks++;
        if (count !== 4'd8) begin
            nerr++; $display("FAIL drop_full got=%0d exp=8", count);
        end
        idle_inputs(); out_pop = 2;
        tick();
        nchecks++;
        if (count !== 4'd6 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL six got cnt=%0d rdy=%b exp 6/1", count, in_ready);
        end
        out_pop = 0; push(32'h1020, 1);
        tick();
        nchecks++;
        if (count !== 4'd7 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL seven got cnt=%0d rdy=%b exp 7/0", count, in_ready);
        end
        push(32'h3000, 2); out_pop = 1;
        tick();
        idle_inputs();
        nchecks++;
        if (count !== 4'd6 || out_pc_0 !== 32'h100c) begin
            nerr++;
            $display("FAIL pop_at7 got cnt=%0d pc=%h exp 6/0000100c",
                     count, out_pc_0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push(32'h4000, 2);
        tick();
        for (int k = 1; k <= 12; k++) begin
            push(32'h4000 + 32'(8 * k), 2); out_pop = 2;
            tick();
            nchecks++;
            if (out_pc_0 !== 32'h4000 + 32'(8 * k) || count !== 4'd2) begin
                nerr++;
                $display("FAIL wrap_%0d got pc=%h cnt=%0d exp pc=%h cnt=2",
                         k, out_pc_0, count, 32'h4000 + 32'(8 * k));
            end
        end
        idle_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        push(32'h5000, 2); in_exc = 2'b10;
        tick();
        idle_inputs();
        nchecks++;
        if (count !== 4'd1 || out_valid_1 !== 1'b0) begin
            nerr++;
            $display("FAIL exc_push got cnt=%0d v1=%b exp 1/0",
                     count, out_valid_1);
        end
        nchecks++;
        if (out_exc_0 !== 2'b10 || out_valid_0 !== 1'b1) begin
            nerr++;
            $display("FAIL exc_head got=%b v0=%b exp 10/1",
                     out_exc_0, out_valid_0);
        end
        out_pop = 2;
        tick();
        out_pop = 0;
        nchecks++;
        if (count !== 4'd0 || out_valid_0 !== 1'b0) begin
            nerr++; $display("FAIL exc_pop got=%0d exp=0", count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        push(32'h6000, 2); tick();
        push(32'h6008, 2); tick();
        push(32'h6010, 1); tick();
        nchecks++;
        if (count !== 4'd5) begin
            nerr++; $display("FAIL pre_flush got=%0d exp=5", count);
        end
        push(32'h6020, 2); out_pop = 1; flush = 1;
        tick();
        idle_inputs();
        nchecks++;
        if (count !== 4'd0 || out_valid_0 !== 1'b0 || out_inst_0 !== '0) begin
            nerr++;
            $display("FAIL flush got cnt=%0d v0=%b inst=%h exp 0/0/0",
                     count, out_valid_0, out_inst_0);
        end
        nchecks++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL flush_ready got=%b exp=1", in_ready);
        end
        push(32'h7000, 2);
        tick();
        idle_inputs();
        nchecks++;
        if (count !== 4'd2 || out_pc_0 !== 32'h7000) begin
            nerr++;
            $display("FAIL post_flush got cnt=%0d pc=%h exp 2/00007000",
                     count, out_pc_0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(32'h8000, 2); tick();
        push(32'h8008, 1); tick();
        idle_inputs();
        nchecks++;
        if (count !== 4'd3) begin
            nerr++; $display("FAIL pre_areset got=%0d exp=3", count);
        end
        #3 reset = 1;
        #1;
        nchecks++;
        if (count !== 4'd0 || in_ready !== 1'b1 || out_valid_0 !== 1'b0
            || out_pc_0 !== '0) begin
            nerr++;
            $display("FAIL async_reset got cnt=%0d rdy=%b v0=%b pc=%h",
                     count, in_ready, out_valid_0, out_pc_0);
        end
        tick();
        reset = 0;
        mq.delete();
    endtask

    task automatic test_random();
        logic        e_v0, e_v1;
        logic [31:0] e_pc0, e_pc1, e_i0, e_i1;
        logic [1:0]  e_x0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid_0 = ($urandom_range(0, 3) != 0);
            in_valid_1 = ($urandom_range(0, 3) != 0);
            in_pc      = $urandom & 32'hfffffffc;
            in_inst_0  = $urandom;
            in_inst_1  = $urandom;
            in_exc     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3))
                                                     : 2'b00;
            out_pop    = 2'($urandom_range(0, 2));
            flush      = ($urandom_range(0, 39) == 0);
            tick();
            model_step();
            e_v0  = mq.size() >= 1;
            e_v1  = mq.size() >= 2 && mq[0].exc == 2'b00;
            e_pc0 = e_v0 ? mq[0].pc   : '0;
            e_i0  = e_v0 ? mq[0].inst : '0;
            e_x0  = e_v0 ? mq[0].exc  : '0;
            e_pc1 = e_v1 ? mq[1].pc   : '0;
            e_i1  = e_v1 ? mq[1].inst : '0;
            nchecks++;
            if (int'(count) !== mq.size()
                || in_ready !== (mq.size() <= DEPTH - 2)) begin
                nerr++;
                $display("FAIL rnd_count c=%0d got=%0d/%b exp=%0d",
                         c, count, in_ready, mq.size());
            end
            nchecks++;
            if ({out_valid_0, out_valid_1} !== {e_v0, e_v1}
                || out_pc_0 !== e_pc0 || out_inst_0 !== e_i0
                || out_exc_0 !== e_x0) begin
                nerr++;
                $display("FAIL rnd_head c=%0d got=%b%b %h %h %b exp=%b%b %h %h %b",
                         c, out_valid_0, out_valid_1, out_pc_0, out_inst_0,
                         out_exc_0, e_v0, e_v1, e_pc0, e_i0, e_x0);
            end
            nchecks++;
            if (out_pc_1 !== e_pc1 || out_inst_1 !== e_i1) begin
                nerr++;
                $display("FAIL rnd_slot1 c=%0d got=%h %h exp=%h %h",
                         c, out_pc_1, out_inst_1, e_pc1, e_i1);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        #2;
        test_reset();
        test_first_push();
        test_fill();
        test_wrap();
        test_exception();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
